// File: rtl/fifo_pkg.sv
// Types and helpers shared by the async FIFO pointer controllers.
package fifo_pkg;

  localparam int DEF_ASIZE = 4;
  localparam int PTR_W     = DEF_ASIZE + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // Correct for any pointer width up to 32 when the caller truncates the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] ptr);
    return ptr ^ (ptr >> 1);
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_binary #(
  parameter int DSIZE = 5
) (
  input  logic [DSIZE-1:0] gray_i,
  output logic [DSIZE-1:0] bin_o
);

  for (genvar gi = 0; gi < DSIZE; gi++) begin : g_bit
    assign bin_o[gi] = ^gray_i[DSIZE-1:gi];
  end

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side controller of the async FIFO: write-pointer sync, read pointer, RAM reads, 2-deep output buffer.
// Define FIFO_RD_LEVEL_EN to add the registered rd_level output (unread RAM words).
module fifo_rd_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DSIZE       = 8,
  parameter int ASIZE       = PTR_W - 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE:0]   wr_ptr_gray,
  output logic [ASIZE:0]   rd_ptr_gray,
  output logic             ram_rd_en,
  output logic [ASIZE-1:0] ram_rd_addr,
  input  logic [DSIZE-1:0] ram_rd_data,
  output logic [DSIZE-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             empty
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ASIZE:0]   rd_level
`endif
);

  localparam int PW = ASIZE + 1;

  logic [PW-1:0] sync_chain [SYNC_STAGES+1];
  logic [PW-1:0] wr_bin_d, wr_bin_q;
  logic [PW-1:0] rd_bin_d, rd_bin_q;
  logic [PW-1:0] rd_gray_d, rd_gray_q;
  logic          empty_d, empty_q;
  buf_state_e    state_d, state_q;
  logic          inflight_q;
  logic [DSIZE-1:0] dout_d, dout_q, skid_d, skid_q;
  logic          dout_valid_d, dout_valid_q, skid_valid_d, skid_valid_q;
  logic          avail, pop, issue;

  assign sync_chain[0] = wr_ptr_gray;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    logic [PW-1:0] stage_q;
    always_ff @(posedge clk) begin
      if (rst) stage_q <= '0;
      else     stage_q <= sync_chain[gi];
    end
    assign sync_chain[gi+1] = stage_q;
  end

  gray_to_binary #(.DSIZE(PW)) u_g2b (
    .gray_i (sync_chain[SYNC_STAGES]),
    .bin_o  (wr_bin_d)
  );

  // Occupancy counts the in-flight RAM word too, so the buffer can never overflow.
  always_comb begin
    avail     = (wr_bin_q != rd_bin_q);
    pop       = dout_valid_q && dout_ready;
    issue     = !rst && avail && ((state_q != TWO) || pop);
    rd_bin_d  = rd_bin_q + PW'(issue);
    rd_gray_d = PW'(bin2gray(32'(rd_bin_d)));
    empty_d   = (wr_bin_d == rd_bin_d);

    state_d = state_q;
    if (issue && !pop) begin
      state_d = (state_q == EMPTY) ? ONE : TWO;
    end else if (!issue && pop) begin
      state_d = (state_q == TWO) ? ONE : EMPTY;
    end
  end

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (pop) begin
      if (skid_valid_q) begin
        dout_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        dout_valid_d = 1'b0;
      end
    end
    // Returning data goes behind whatever dout will hold after this clock's pop.
    if (inflight_q) begin
      if (!dout_valid_d) begin
        dout_d       = ram_rd_data;
        dout_valid_d = 1'b1;
      end else begin
        skid_d       = ram_rd_data;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin_q     <= '0;
      rd_bin_q     <= '0;
      rd_gray_q    <= '0;
      empty_q      <= 1'b1;
      state_q      <= EMPTY;
      inflight_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      wr_bin_q     <= wr_bin_d;
      rd_bin_q     <= rd_bin_d;
      rd_gray_q    <= rd_gray_d;
      empty_q      <= empty_d;
      state_q      <= state_d;
      inflight_q   <= issue;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] rd_level_q;
  always_ff @(posedge clk) begin
    if (rst) rd_level_q <= '0;
    else     rd_level_q <= wr_bin_d - rd_bin_d;
  end
  assign rd_level = rd_level_q;
`endif

  assign rd_ptr_gray = rd_gray_q;
  assign ram_rd_en   = issue;
  assign ram_rd_addr = rd_bin_q[ASIZE-1:0];
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign empty       = empty_q;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Self-checking bench for fifo_rd_ptr_ctrl: vector table, directed corner cases, random traffic vs scoreboard.
module tb_fifo_rd_ptr_ctrl;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int PW    = ASIZE + 1;
  localparam int DEPTH = 16;
  localparam int HIST  = 40;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [PW-1:0]    wr_ptr_gray = '0;
  logic [PW-1:0]    rd_ptr_gray;
  logic             ram_rd_en;
  logic [ASIZE-1:0] ram_rd_addr;
  logic [DSIZE-1:0] ram_rd_data = '0;
  logic [DSIZE-1:0] dout;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic             empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0]    rd_level;
`endif

  always #5 clk = ~clk;

  fifo_rd_ptr_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .empty       (empty)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level    (rd_level)
`endif
  );

  typedef struct {
    bit         wr;
    bit         ready;
    bit         e_empty;
    bit         e_rd_en;
    bit         e_valid;
    logic [4:0] e_gray;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [DSIZE-1:0] exp_q [$];
  int wr_cnt  = 0;
  int wr_todo = 0;
  int iss_cnt = 0;
  int pop_cnt = 0;
  bit mon_en  = 1'b0;

  vec_t tbl [7];
  bit   en_hist  [HIST];
  bit   val_hist [HIST];
  logic [ASIZE-1:0] wrap_addr [$];
  logic [PW-1:0]    wrap_gray [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [PW-1:0] gray_of(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic int longest_run(input bit h [HIST]);
    int best = 0;
    int cur  = 0;
    for (int i = 0; i < HIST; i++) begin
      cur  = h[i] ? cur + 1 : 0;
      best = (cur > best) ? cur : best;
    end
    return best;
  endfunction

  function automatic int ones(input bit h [HIST]);
    int n = 0;
    for (int i = 0; i < HIST; i++) n += int'(h[i]);
    return n;
  endfunction

  // Synchronous-read RAM model; writes come from the bench writer below.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  // One clock: after the edge, optionally write one word and advance the Gray write pointer.
  task automatic step();
    logic [DSIZE-1:0] d;
    @(posedge clk);
    #1;
    if (!rst && wr_todo > 0 && (wr_cnt - iss_cnt) < DEPTH) begin
      d = DSIZE'($urandom);
      mem[wr_cnt % DEPTH] = d;
      exp_q.push_back(d);
      wr_cnt++;
      wr_todo--;
      wr_ptr_gray = gray_of(wr_cnt);
    end
  endtask

  task automatic clear_model();
    wr_cnt      = 0;
    wr_todo     = 0;
    iss_cnt     = 0;
    pop_cnt     = 0;
    wr_ptr_gray = '0;
    exp_q.delete();
  endtask

  task automatic do_reset(input int n);
    mon_en     = 1'b0;
    rst        = 1'b1;
    dout_ready = 1'b0;
    clear_model();
    repeat (n) step();
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  // Scoreboard: FIFO order, stability under backpressure, read address/pointer per issued read.
  logic             prev_hold = 1'b0;
  logic [DSIZE-1:0] prev_dout = '0;
  always @(posedge clk) begin
    #3;
    if (!mon_en) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(dout_valid), 32'd1);
        chk("hold_data", 32'(dout), 32'(prev_dout));
      end
      if (ram_rd_en) begin
        chk("rd_addr", 32'(ram_rd_addr), 32'(iss_cnt % DEPTH));
        chk("rd_gray_at_issue", 32'(rd_ptr_gray), 32'(gray_of(iss_cnt)));
        iss_cnt++;
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) chk("pop_with_nothing_written", 32'd1, 32'd0);
        else                   chk("dout_order", 32'(dout), 32'(exp_q.pop_front()));
        pop_cnt++;
      end
      prev_hold = dout_valid && !dout_ready;
      prev_dout = dout;
    end
  end

  initial begin
    // Single write with ready high: per-clock expectations after the write.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00001};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00001};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00001};

    // Reset, idle
    do_reset(3);
    #1;
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_dout_valid", 32'(dout_valid), 32'd0);
    chk("reset_rd_en", 32'(ram_rd_en), 32'd0);
    chk("reset_rd_gray", 32'(rd_ptr_gray), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
    chk("reset_rd_level", 32'(rd_level), 32'd0);
`endif

    // Single write, table-driven
    for (int i = 0; i < 7; i++) begin
      wr_todo += int'(tbl[i].wr);
      step();
      dout_ready = tbl[i].ready;
      #1;
      chk($sformatf("single_empty[%0d]", i), 32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("single_rd_en[%0d]", i), 32'(ram_rd_en), 32'(tbl[i].e_rd_en));
      chk($sformatf("single_valid[%0d]", i), 32'(dout_valid), 32'(tbl[i].e_valid));
      chk($sformatf("single_rd_gray[%0d]", i), 32'(rd_ptr_gray), 32'(tbl[i].e_gray));
    end
    chk("single_pops", 32'(pop_cnt), 32'd1);

    // Burst of 8 at full rate
    do_reset(2);
    dout_ready = 1'b1;
    wr_todo    = 8;
    for (int c = 0; c < HIST; c++) begin
      step();
      #1;
      en_hist[c]  = ram_rd_en;
      val_hist[c] = dout_valid;
    end
    chk("burst_issues", 32'(ones(en_hist)), 32'd8);
    chk("burst_issue_run", 32'(longest_run(en_hist)), 32'd8);
    chk("burst_valid_run", 32'(longest_run(val_hist)), 32'd8);
    chk("burst_pops", 32'(pop_cnt), 32'd8);
    chk("burst_rd_gray_end", 32'(rd_ptr_gray), 32'b01100);

    // Backpressure: two reads fill the buffer, then stall
    do_reset(2);
    wr_todo = 8;
    repeat (20) step();
    #1;
    chk("bp_issues_stalled", 32'(iss_cnt), 32'd2);
    chk("bp_dout_valid", 32'(dout_valid), 32'd1);
    chk("bp_dout_is_first", 32'(dout), 32'(exp_q[0]));
    chk("bp_not_empty", 32'(empty), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
    chk("bp_rd_level", 32'(rd_level), 32'd6);
`endif
    dout_ready = 1'b1;
    for (int c = 0; c < 60 && pop_cnt < 8; c++) step();
    repeat (3) step();
    chk("bp_total_issues", 32'(iss_cnt), 32'd8);
    chk("bp_total_pops", 32'(pop_cnt), 32'd8);
    chk("bp_nothing_left", 32'(exp_q.size()), 32'd0);

    // Pointer wrap: 30 words through, then 4 more across the 31->0 boundary
    do_reset(2);
    dout_ready = 1'b1;
    wr_todo    = 30;
    for (int c = 0; c < 300 && pop_cnt < 30; c++) step();
    chk("wrap_preload_pops", 32'(pop_cnt), 32'd30);
    wr_todo = 4;
    for (int c = 0; c < 30; c++) begin
      step();
      #1;
      if (ram_rd_en) begin
        wrap_addr.push_back(ram_rd_addr);
        wrap_gray.push_back(rd_ptr_gray);
      end
    end
    chk("wrap_issue_count", 32'(wrap_addr.size()), 32'd4);
    if (wrap_addr.size() == 4) begin
      chk("wrap_addr0", 32'(wrap_addr[0]), 32'd14);
      chk("wrap_addr1", 32'(wrap_addr[1]), 32'd15);
      chk("wrap_addr2", 32'(wrap_addr[2]), 32'd0);
      chk("wrap_addr3", 32'(wrap_addr[3]), 32'd1);
      chk("wrap_gray_31", 32'(wrap_gray[1]), 32'b10000);
      chk("wrap_gray_0", 32'(wrap_gray[2]), 32'b00000);
    end
    chk("wrap_rd_gray_end", 32'(rd_ptr_gray), 32'b00011);

    // Reset in the middle of a burst
    do_reset(2);
    dout_ready = 1'b1;
    wr_todo    = 8;
    for (int c = 0; c < 60 && pop_cnt < 4; c++) step();
    chk("midrst_reached_word4", 32'(pop_cnt), 32'd4);
    mon_en = 1'b0;
    rst    = 1'b1;
    step();
    #1;
    chk("midrst_dout_valid", 32'(dout_valid), 32'd0);
    chk("midrst_rd_gray", 32'(rd_ptr_gray), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
`ifdef FIFO_RD_LEVEL_EN
    chk("midrst_rd_level", 32'(rd_level), 32'd0);
`endif

    // Random traffic against the scoreboard
    do_reset(2);
    wr_todo = 150;
    for (int c = 0; c < 3000 && (pop_cnt < 150 || wr_todo > 0); c++) begin
      step();
      dout_ready = ($urandom_range(0, 3) != 0);
    end
    dout_ready = 1'b1;
    repeat (8) step();
    #1;
    chk("rand_pops", 32'(pop_cnt), 32'd150);
    chk("rand_issues", 32'(iss_cnt), 32'd150);
    chk("rand_nothing_left", 32'(exp_q.size()), 32'd0);
    chk("rand_empty_after", 32'(empty), 32'd1);
    chk("rand_valid_after", 32'(dout_valid), 32'd0);
    chk("rand_rd_gray_end", 32'(rd_ptr_gray), 32'(gray_of(150)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
